// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, counter sizing
// and the divide-by-zero quotient pattern.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Iteration counter must hold 0..WIDTH-1; WIDTH+1 keeps WIDTH a power of two safe.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Sliced down to WIDTH at the point of use (WIDTH <= 32).
  localparam logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_sign_fix.sv
// Combinational conditional two's-complement negate; used for operand
// magnitudes on entry and for applying result signs in FIX.
module div_sign_fix #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  assign res = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle non-restoring divider, one quotient bit per clock, with
// optional signed mode (truncating toward zero) and divide-by-zero flag.
import div_pkg::*;

module seq_divider #(
  parameter int WIDTH     = 16,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);

  div_state_t       state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   a_q;      // partial remainder, sign in MSB
  logic [WIDTH-1:0] q_q;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH:0]   m_q;      // divisor magnitude
  logic             sign_q, sign_r;

  logic             mode, dvd_neg, dsr_neg, dsr_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dsr_ext, dsr_mag;
  logic [WIDTH:0]   a_sh, a_nx;
  logic [WIDTH-1:0] rem_mag, quo_res, rem_res;

  // Constant-folds the signed path away when SIGNED_EN is 0.
  assign mode     = (SIGNED_EN != 0) & is_signed;
  assign dvd_neg  = mode & dividend[WIDTH-1];
  assign dsr_neg  = mode & divisor[WIDTH-1];
  assign dsr_zero = (divisor == '0);
  assign dsr_ext  = {dsr_neg, divisor};

  // A WIDTH-bit negate of the most-negative value yields the right magnitude
  // when read unsigned, so the dividend needs no extra bit.
  div_sign_fix #(.WIDTH(WIDTH))   u_dvd_abs (.val(dividend), .neg(dvd_neg), .res(dvd_mag));
  div_sign_fix #(.WIDTH(WIDTH+1)) u_dsr_abs (.val(dsr_ext),  .neg(dsr_neg), .res(dsr_mag));

  assign a_sh = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign a_nx = a_q[WIDTH] ? (a_sh + m_q) : (a_sh - m_q);

  // Restore step: a negative partial remainder is one divisor short.
  assign rem_mag = a_q[WIDTH-1:0] + (a_q[WIDTH] ? m_q[WIDTH-1:0] : '0);

  div_sign_fix #(.WIDTH(WIDTH)) u_quo_sgn (.val(q_q),     .neg(sign_q), .res(quo_res));
  div_sign_fix #(.WIDTH(WIDTH)) u_rem_sgn (.val(rem_mag), .neg(sign_r), .res(rem_res));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = dsr_zero ? DONE : CALC;
      CALC:    if (cnt == CW'(WIDTH-1)) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt    <= '0;
          a_q    <= '0;
          q_q    <= dvd_mag;
          m_q    <= dsr_mag;
          sign_q <= dvd_neg ^ dsr_neg;
          sign_r <= dvd_neg;
          if (dsr_zero) begin
            quotient    <= DBZ_QUOT[WIDTH-1:0];
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          a_q <= a_nx;
          q_q <= {q_q[WIDTH-2:0], ~a_nx[WIDTH]};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          quotient  <= quo_res;
          remainder <= rem_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (WIDTH=16): directed vector table, start-ignore,
// reset-abort sequences, then random operations against an arithmetic model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst, start, is_signed;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(16), .SIGNED_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        s;
    logic [15:0] q, r;
    logic        z;
    int          lat;
    int          inj;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Divider semantics from plain integer arithmetic (truncating division).
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] q, output logic [15:0] r, output logic z);
    longint sa, sb;
    if (b == 16'h0) begin
      q = 16'hFFFF; r = a; z = 1'b1;
      return;
    end
    z = 1'b0;
    if (s) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
    end else begin
      sa = longint'(a); sb = longint'(b);
    end
    q = 16'(sa / sb);
    r = 16'(sa % sb);
  endfunction

  // Issue one operation from IDLE, track latency and busy, optionally inject
  // a start with different operands in cycle inj, then check the idle cycle.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] eq, input logic [15:0] er,
                        input logic ez, input int elat, input int inj);
    int  lat;
    bit  busy_ok;
    lat     = -1;
    busy_ok = 1'b1;
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (inj != 0 && c == inj + 1) start = 1'b0;
      if (c == inj) begin
        start = 1'b1; dividend = 16'h0007; divisor = 16'h0007; is_signed = ~s;
      end
      if (c == 1 && b != 16'h0) chk({name, " dbz_clear"}, div_by_zero, 1'b0);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin lat = c; break; end
    end
    chk({name, " latency"}, lat, elat);
    chk({name, " busy"}, busy_ok, 1'b1);
    chk({name, " quotient"}, quotient, eq);
    chk({name, " remainder"}, remainder, er);
    chk({name, " div_by_zero"}, div_by_zero, ez);
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, " idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    logic [15:0] a, b, eq, er;
    logic        s, ez;
    int          seen;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs", {busy, done, quotient, remainder, div_by_zero}, 35'h0);
    rst = 1'b0;

    vecs.push_back('{16'd100,  16'd7,    1'b0, 16'h000E, 16'h0002, 1'b0, 18, 0});
    vecs.push_back('{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 18, 0});
    vecs.push_back('{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 18, 0});
    vecs.push_back('{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1,  0});
    vecs.push_back('{16'h0009, 16'h0003, 1'b0, 16'h0003, 16'h0000, 1'b0, 18, 0});
    vecs.push_back('{16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1,  0});
    vecs.push_back('{16'h0009, 16'h0003, 1'b1, 16'h0003, 16'h0000, 1'b0, 18, 0});
    vecs.push_back('{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 18, 0});
    vecs.push_back('{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 18, 0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 18, 0});
    vecs.push_back('{16'h0000, 16'hFFFB, 1'b1, 16'h0000, 16'h0000, 1'b0, 18, 0});
    vecs.push_back('{16'd1000, 16'd10,   1'b0, 16'd100,  16'h0000, 1'b0, 18, 5});
    vecs.push_back('{16'hFF9C, 16'd7,    1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 18, 18});
    vecs.push_back('{16'h0042, 16'h0000, 1'b1, 16'hFFFF, 16'h0042, 1'b1, 1,  1});

    // Consecutive entries are issued back-to-back: start in the cycle after done.
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
             vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat, vecs[i].inj);

    // Reset in cycle 8 of an operation aborts it without a late done.
    start = 1'b1; dividend = 16'd5000; divisor = 16'd3; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort outs", {busy, done, quotient, remainder, div_by_zero}, 35'h0);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("abort no stale done", seen, 0);
    run_op("after abort", 16'd5000, 16'd3, 1'b0, 16'd1666, 16'd2, 1'b0, 18, 0);

    for (int n = 0; n < 200; n++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'h0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = 16'hFFFF;
        3:       a = 16'h8000 ^ 16'($urandom_range(0, 1));
        default: b = 16'($urandom);
      endcase
      if (b == 16'h0 && $urandom_range(0, 3) != 0) b = 16'($urandom_range(1, 255));
      s = 1'($urandom);
      model(a, b, s, eq, er, ez);
      run_op($sformatf("rand%0d %h/%h s%0d", n, a, b, s), a, b, s, eq, er, ez,
             (b == 16'h0) ? 1 : 18, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
